// File: rtl/pc_fetch_sequencer.sv
// PC holder and instruction-fetch sequencer (RST -> FETCH <-> HOLD, ERR on fetch timeout).
// Optional fetch-timeout watchdog is built only when FETCH_TIMEOUT_EN is defined.
module pc_fetch_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h00100000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] new_pc,
    output logic [29:0] pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] fetch_count,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StRst, StFetch, StHold, StErr} state_e;

    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..15");
    end

    state_e      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    // Set on every reset edge; keeps RST for one extra cycle after reset is released.
    logic        rst_hold_q, rst_hold_d;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] TmoLast = 4'(TIMEOUT - 1);
    logic [3:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRst;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            count_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            rst_hold_q    <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            tmo_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            count_q       <= count_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            rst_hold_q    <= rst_hold_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_q         <= tmo_d;
            err_q         <= err_d;
`endif
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        count_d    = count_q;
        rst_hold_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            StRst: begin
                if (!rst_hold_q) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StHold;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (tmo_q == TmoLast) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        tmo_d = tmo_q + 4'd1;
                    end
`endif
                end
            end
            StHold: begin
                if (instr_ready) begin
                    pc_d    = new_pc;
                    count_d = count_q + 32'd1;
                    state_d = StFetch;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StRst;
            end
        endcase
    end

    // Output decode from the next state so the strobes leave the chip registered
    always_comb begin
        imem_req_d    = (state_d == StFetch);
        instr_valid_d = (state_d == StHold);
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = count_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Holds the architectural program counter and sequences instruction fetches from instruction memory for the single-cycle datapath. It sits directly upstream of `instruction_fetch_unit`. It presents the current word-address PC to that unit and issues a request/acknowledge fetch at that address. It hands the fetched word to decode, and it loads the unit's computed `new_pc` when decode accepts the instruction.

## Interface
Parameters:
- `RESET_PC`, 30'h00100000, word address loaded on reset (byte address 0x00400000)
- `TIMEOUT`, 15, max cycles to wait for `imem_ack` before flagging an error (4-bit counter, legal range 1–15)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `new_pc`  in  30  next PC from `instruction_fetch_unit`
- `pc`  out  30  current PC, to `instruction_fetch_unit` and branch logic
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  30  fetch word address, always equal to `pc`
- `imem_ack`  in  1  memory has returned data on `imem_rdata` this cycle
- `imem_rdata`  in  32  instruction word
- `instr`  out  32  registered instruction to decode
- `instr_valid`  out  1  `instr` holds a valid instruction
- `instr_ready`  in  1  decode consumes `instr` this cycle
- `fetch_count`  out  32  number of instructions accepted by decode
- `fetch_err`  out  1  sticky fetch-timeout flag

## Operation
- FSM states:
  - RST: entered only by reset.
  - FETCH: `imem_req`=1.
  - HOLD: `instr_valid`=1.
  - ERR: terminal.
- Reset, sampled at a rising edge:
  - `pc`=`RESET_PC`, `instr`=0, `fetch_count`=0, `fetch_err`=0, timeout counter=0.
  - `imem_req`=0, `instr_valid`=0.
  - State goes to RST.
  - Reset wins over every other event, including mid-fetch and in ERR.
- RST: unconditionally moves to FETCH on the next edge.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: latch `instr`←`imem_rdata`, clear the timeout counter, go to HOLD.
  - Otherwise increment the timeout counter.
- HOLD:
  - `instr_valid`=1 and `instr` stays stable; `imem_req`=0.
  - On `instr_ready`=1: `pc`←`new_pc`, `fetch_count`←`fetch_count`+1 (mod 2^32, wraps 0xFFFFFFFF→0), go to FETCH.
  - `new_pc` is sampled only on that edge.
- `imem_ack` outside FETCH is ignored.
- `instr_ready` outside HOLD is ignored and does not change `pc`.
- `pc` changes only on reset or on a HOLD-state accept. It does not change during FETCH, and `new_pc` from a stale cycle is never taken.
- `new_pc` is loaded as-is. Wrap from 30'h3FFFFFFF to 0 is the IFU's arithmetic and is not checked here.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Fetch after reset:
  - Reset released before edge N: state is RST after N.
  - FETCH with `imem_req`=1 after N+1.
- Fetch latency:
  - Zero-wait memory: `imem_ack` is high in the first FETCH cycle, so `instr_valid`=1 one cycle after `imem_req` rises.
  - Each wait cycle adds one cycle.
- Back-to-back: with `instr_ready` held high, one instruction is delivered every 2 cycles (FETCH, HOLD alternating).
- `instr_valid` and `imem_req` are never high in the same cycle.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - In FETCH, if the counter reaches `TIMEOUT` with no ack, then on that edge `imem_req`→0, `fetch_err`→1, and state goes to ERR.
  - An ack in the same cycle the counter hits `TIMEOUT` takes priority: the data is accepted and there is no error.
  - ERR holds all outputs except `fetch_err`=1 at their idle values (`imem_req`=0, `instr_valid`=0, `pc` frozen) until reset.
- Not defined:
  - No counter is built; FETCH waits indefinitely.
  - `fetch_err` is tied 0 and ERR is unreachable.

## Test plan
- Reset with zero-wait memory, `instr_ready`=1, `new_pc`=`pc`+1: `imem_addr` sequence is 0x00100000, 0x00100001, 0x00100002. `instr_valid` pulses every 2nd cycle. `fetch_count`=3 after the third accept.
- Memory with 3 wait states: `imem_req` stays high 4 cycles at a stable address, then `instr` equals `imem_rdata` (e.g. 0x8C220004) with `instr_valid`=1 the next cycle.
- Decode stalls with `instr_ready`=0 for 5 cycles while `new_pc` toggles: `instr` and `pc` remain unchanged. On the accept edge `pc` equals the `new_pc` value present that cycle (branch target 0x00100040).
- Reset asserted during FETCH, and again during HOLD: the next cycle shows `imem_req`=0, `instr_valid`=0, `pc`=0x00100000, `fetch_count`=0. Fetch resumes 2 cycles after release.
- With `FETCH_TIMEOUT_EN` and `TIMEOUT`=15:
  - No ack for 15 cycles: `fetch_err`=1 and `imem_req`=0, holding until reset.
  - Ack exactly on cycle 15: no error.
  - Without the macro, fetch stalls indefinitely and `fetch_err` stays 0.
- Preload `fetch_count` to near-max by running 2^32-style forced state in the bench: 0xFFFFFFFF plus one accept gives 0x00000000.
